// File: rtl/controller_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, ALU operations, FSM states and
// the latched instruction class.
package controller_pkg;

  localparam logic [6:0] OPCODE_R   = 7'b0110011;
  localparam logic [6:0] OPCODE_LD  = 7'b0000011;
  localparam logic [6:0] OPCODE_SD  = 7'b0100011;
  localparam logic [6:0] OPCODE_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsNop = 3'd0,
    ClsR   = 3'd1,
    ClsLd  = 3'd2,
    ClsSd  = 3'd3,
    ClsBeq = 3'd4
  } opcode_class_e;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-class decode; anything unrecognised maps to ClsNop.
module opcode_classifier
  import controller_pkg::*;
(
  input  logic [6:0]    opcode_i,
  output opcode_class_e class_o
);

  always_comb begin
    class_o = ClsNop;
    case (opcode_i)
      OPCODE_R:   class_o = ClsR;
      OPCODE_LD:  class_o = ClsLd;
      OPCODE_SD:  class_o = ClsSd;
      OPCODE_BEQ: class_o = ClsBeq;
      default:    class_o = ClsNop;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT) with memory wait
// timeout and retired-instruction counter. Define ILLEGAL_OPCODE_TRAP_EN to fault on unknown
// opcodes instead of retiring them as NOPs.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT  = 15,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic                   zero,
  input  logic                   memoryReady,
  output logic                   instructionRead,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   pcSourceBranch,
  output logic                   ALUSrc,
  output logic [1:0]             ALUOp,
  output logic                   memoryRead,
  output logic                   memoryWrite,
  output logic                   memoryToRegister,
  output logic                   regWrite,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

  state_e                 state_q, state_d;
  opcode_class_e          class_q, class_d;
  opcode_class_e          dec_class;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic                   fault_q, fault_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   retire;
  logic                   timeout;

  opcode_classifier u_classifier (
    .opcode_i (opcode),
    .class_o  (dec_class)
  );

  // This is the WAIT_LIMIT-th consecutive not-ready cycle; a ready in this cycle still succeeds.
  assign timeout = !memoryReady && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    wait_d  = '0;
    fault_d = fault_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (memoryReady) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        class_d = dec_class;
        if (dec_class == ClsNop) begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
          state_d = StHalt;
          fault_d = 1'b1;
`else
          state_d = StFetch;
          retire  = 1'b1;
`endif
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        case (class_q)
          ClsR:        state_d = StWriteback;
          ClsLd, ClsSd: state_d = StMemory;
          default: begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        endcase
      end
      StMemory: begin
        if (memoryReady) begin
          if (class_q == ClsLd) begin
            state_d = StWriteback;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end else if (timeout) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWriteback: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
    retired_d = retired_q + COUNT_WIDTH'(retire);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      class_q   <= ClsNop;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Controls are decoded from state; reset overrides so no strobe leaks out of an aborted op.
  always_comb begin
    instructionRead  = 1'b0;
    irWrite          = 1'b0;
    pcWrite          = 1'b0;
    pcSourceBranch   = 1'b0;
    ALUSrc           = 1'b0;
    ALUOp            = ALUOP_ADD;
    memoryRead       = 1'b0;
    memoryWrite      = 1'b0;
    memoryToRegister = 1'b0;
    regWrite         = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          instructionRead = !timeout;
          irWrite         = memoryReady;
          pcWrite         = memoryReady;
        end
        StExecute: begin
          case (class_q)
            ClsR: begin
              ALUOp = ALUOP_FUNCT;
            end
            ClsLd, ClsSd: begin
              ALUSrc = 1'b1;
            end
            ClsBeq: begin
              ALUOp          = ALUOP_SUB;
              pcSourceBranch = 1'b1;
              pcWrite        = zero;
            end
            default: ;
          endcase
        end
        StMemory: begin
          ALUSrc      = 1'b1;
          memoryRead  = (class_q == ClsLd) && !timeout;
          memoryWrite = (class_q == ClsSd) && !timeout;
        end
        StWriteback: begin
          regWrite         = 1'b1;
          memoryToRegister = (class_q == ClsLd);
        end
        default: ;
      endcase
    end
  end

  assign fault        = fault_q;
  assign retiredCount = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected control vectors are queued as each
// cycle's stimulus is driven and compared against the DUT at the following negative edge.
module tb_multicycle_controller;

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSd  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpIll = 7'b1111111;

  // {instructionRead, irWrite, pcWrite, pcSourceBranch, ALUSrc, ALUOp, memoryRead,
  //  memoryWrite, memoryToRegister, regWrite}
  localparam logic [10:0] VIdle = 11'b00000_00_0000;
  localparam logic [10:0] VFreq = 11'b10000_00_0000;
  localparam logic [10:0] VFgo  = 11'b11100_00_0000;
  localparam logic [10:0] VExR  = 11'b00000_10_0000;
  localparam logic [10:0] VExM  = 11'b00001_00_0000;
  localparam logic [10:0] VBeq1 = 11'b00110_01_0000;
  localparam logic [10:0] VBeq0 = 11'b00010_01_0000;
  localparam logic [10:0] VLd   = 11'b00001_00_1000;
  localparam logic [10:0] VSd   = 11'b00001_00_0100;
  localparam logic [10:0] VWbR  = 11'b00000_00_0001;
  localparam logic [10:0] VWbLd = 11'b00000_00_0011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = OpR;
  logic        zero = 1'b0;
  logic        memoryReady = 1'b1;
  logic        instructionRead, irWrite, pcWrite, pcSourceBranch, ALUSrc;
  logic [1:0]  ALUOp;
  logic        memoryRead, memoryWrite, memoryToRegister, regWrite, fault;
  logic [15:0] retiredCount;
  logic [10:0] ctrl_obs;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] ctrl;
  } exp_t;
  exp_t exp_q[$];

  multicycle_controller #(
    .WAIT_LIMIT  (15),
    .COUNT_WIDTH (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .opcode           (opcode),
    .zero             (zero),
    .memoryReady      (memoryReady),
    .instructionRead  (instructionRead),
    .irWrite          (irWrite),
    .pcWrite          (pcWrite),
    .pcSourceBranch   (pcSourceBranch),
    .ALUSrc           (ALUSrc),
    .ALUOp            (ALUOp),
    .memoryRead       (memoryRead),
    .memoryWrite      (memoryWrite),
    .memoryToRegister (memoryToRegister),
    .regWrite         (regWrite),
    .fault            (fault),
    .retiredCount     (retiredCount)
  );

  always #5 clock = ~clock;

  assign ctrl_obs = {instructionRead, irWrite, pcWrite, pcSourceBranch, ALUSrc, ALUOp,
                     memoryRead, memoryWrite, memoryToRegister, regWrite};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic mr, input logic z, input logic [6:0] op,
                       input string tag, input logic [10:0] ctrl);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    memoryReady = mr;
    zero        = z;
    opcode      = op;
    e.tag  = tag;
    e.ctrl = ctrl;
    exp_q.push_back(e);
    @(negedge clock);
    e = exp_q.pop_front();
    check_eq(e.tag, 32'(ctrl_obs), 32'(e.ctrl));
  endtask

  task automatic fetch_go(input logic [6:0] op);
    cycle(1'b0, 1'b1, 1'b0, op, "fetch_go", VFgo);
  endtask

  initial begin
    cycle(1'b1, 1'b1, 1'b1, OpR, "rst_ctrl", VIdle);
    cycle(1'b1, 1'b1, 1'b1, OpR, "rst_ctrl", VIdle);
    check_eq("rst_retired", 32'(retiredCount), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);

    // R with a fetch that completes on the last permitted wait cycle
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b0, OpR, "fetch_wait", VFreq);
    cycle(1'b0, 1'b1, 1'b0, OpR, "fetch_limit_ok", VFgo);
    cycle(1'b0, 1'b1, 1'b0, OpR, "r_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b0, OpR, "r_execute", VExR);
    cycle(1'b0, 1'b1, 1'b0, OpR, "r_writeback", VWbR);

    fetch_go(OpLd);
    check_eq("retired_r", 32'(retiredCount), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, OpLd, "ld_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b0, OpLd, "ld_execute", VExM);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, OpLd, "ld_mem_wait", VLd);
    cycle(1'b0, 1'b1, 1'b0, OpLd, "ld_mem_ready", VLd);
    cycle(1'b0, 1'b0, 1'b0, OpLd, "ld_writeback", VWbLd);

    fetch_go(OpBeq);
    check_eq("retired_ld", 32'(retiredCount), 32'd2);
    cycle(1'b0, 1'b1, 1'b1, OpBeq, "beq1_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b1, OpBeq, "beq1_execute", VBeq1);

    fetch_go(OpBeq);
    check_eq("retired_beq1", 32'(retiredCount), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, OpBeq, "beq0_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b0, OpBeq, "beq0_execute", VBeq0);

    fetch_go(OpSd);
    check_eq("retired_beq0", 32'(retiredCount), 32'd4);
    cycle(1'b0, 1'b1, 1'b0, OpSd, "sd_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b0, OpSd, "sd_execute", VExM);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, OpSd, "sd_mem_wait", VSd);
    cycle(1'b0, 1'b1, 1'b0, OpSd, "sd_mem_ready", VSd);

    // Fetch timeout: 14 waiting cycles, request dropped on the 15th, then HALT
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b0, OpR, "to_wait", VFreq);
    check_eq("retired_sd", 32'(retiredCount), 32'd5);
    cycle(1'b0, 1'b0, 1'b0, OpR, "to_drop", VIdle);
    check_eq("to_fault_pre", 32'(fault), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, OpR, "halt_ctrl", VIdle);
    check_eq("halt_fault", 32'(fault), 32'd1);
    check_eq("halt_retired", 32'(retiredCount), 32'd5);

    // Reset aborting an SD in MEMORY
    cycle(1'b1, 1'b1, 1'b0, OpR, "rst2_ctrl", VIdle);
    fetch_go(OpR);
    check_eq("rst2_fault", 32'(fault), 32'd0);
    check_eq("rst2_retired", 32'(retiredCount), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, OpR, "r2_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b0, OpR, "r2_execute", VExR);
    cycle(1'b0, 1'b1, 1'b0, OpR, "r2_writeback", VWbR);
    fetch_go(OpSd);
    check_eq("retired_r2", 32'(retiredCount), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, OpSd, "sd2_decode", VIdle);
    cycle(1'b0, 1'b1, 1'b0, OpSd, "sd2_execute", VExM);
    cycle(1'b0, 1'b0, 1'b0, OpSd, "sd2_mem_wait", VSd);
    cycle(1'b1, 1'b1, 1'b0, OpSd, "sd2_rst_no_write", VIdle);
    cycle(1'b0, 1'b0, 1'b0, OpSd, "sd2_restart_fetch", VFreq);
    check_eq("sd2_retired_cleared", 32'(retiredCount), 32'd0);
    check_eq("sd2_fault", 32'(fault), 32'd0);

    // Unknown opcode
    fetch_go(OpIll);
    cycle(1'b0, 1'b1, 1'b0, OpIll, "ill_decode", VIdle);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    cycle(1'b0, 1'b1, 1'b0, OpIll, "ill_halt", VIdle);
    check_eq("ill_fault", 32'(fault), 32'd1);
    check_eq("ill_retired", 32'(retiredCount), 32'd0);
`else
    cycle(1'b0, 1'b0, 1'b0, OpIll, "nop_fetch", VFreq);
    check_eq("nop_fault", 32'(fault), 32'd0);
    check_eq("nop_retired", 32'(retiredCount), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
